// File: rtl/serial_pkg.sv
// Shared definitions for the serial port TX path.
// Holds the TX sequencer state encoding, the SCON mode constants ({sm0, sm1})
// and the default payload width.
package serial_pkg;

    localparam int unsigned DEFAULT_DATA_BITS = 8;

    // Mode value as {SCON.7 sm0, SCON.6 sm1}
    localparam logic [1:0] MODE0 = 2'b00;  // synchronous shift
    localparam logic [1:0] MODE1 = 2'b01;  // 10-bit frame
    localparam logic [1:0] MODE2 = 2'b10;  // 11-bit frame
    localparam logic [1:0] MODE3 = 2'b11;  // 11-bit frame, same as MODE2 here

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StStart,
        StData,
        StNinth,
        StStop,
        StM0Lo,
        StM0Hi
    } tx_state_e;

endpackage

// File: rtl/serial_tx_sequencer_if.sv
// Bus bundle between the SFR/baud side and the TX sequencer.
// Signals:
//   serial_br_i            baud tick (one-cycle pulse)
//   serial_scon7_sm0_i     SCON.7 mode bit
//   serial_scon6_sm1_i     SCON.6 mode bit
//   serial_scon3_tb8_i     ninth bit for modes 2/3
//   serial_sbuf_wr_i       SBUF write strobe
//   serial_sbuf_data_i     byte written to SBUF
//   serial_txd_o           P3.1 value (data in modes 1-3, shift clock in mode 0)
//   serial_rxd_o           P3.0 value (data in mode 0)
//   serial_p3en_0_o        P3.0 output enable
//   serial_p3en_1_o        P3.1 output enable
//   serial_scon1_ti_set_o  one-cycle TI set request
//   serial_busy_o          transfer in progress
// Modports: master drives the request side, slave is the sequencer.
interface serial_tx_sequencer_if #(
    parameter int unsigned DATA_BITS = serial_pkg::DEFAULT_DATA_BITS
);
    logic                 serial_br_i;
    logic                 serial_scon7_sm0_i;
    logic                 serial_scon6_sm1_i;
    logic                 serial_scon3_tb8_i;
    logic                 serial_sbuf_wr_i;
    logic [DATA_BITS-1:0] serial_sbuf_data_i;
    logic                 serial_txd_o;
    logic                 serial_rxd_o;
    logic                 serial_p3en_0_o;
    logic                 serial_p3en_1_o;
    logic                 serial_scon1_ti_set_o;
    logic                 serial_busy_o;

    modport master (
        output serial_br_i, serial_scon7_sm0_i, serial_scon6_sm1_i, serial_scon3_tb8_i,
               serial_sbuf_wr_i, serial_sbuf_data_i,
        input  serial_txd_o, serial_rxd_o, serial_p3en_0_o, serial_p3en_1_o,
               serial_scon1_ti_set_o, serial_busy_o
    );

    modport slave (
        input  serial_br_i, serial_scon7_sm0_i, serial_scon6_sm1_i, serial_scon3_tb8_i,
               serial_sbuf_wr_i, serial_sbuf_data_i,
        output serial_txd_o, serial_rxd_o, serial_p3en_0_o, serial_p3en_1_o,
               serial_scon1_ti_set_o, serial_busy_o
    );
endinterface

// File: rtl/serial_tx_shifter.sv
// Parallel-load, LSB-first shift register for the TX payload.
// Ports:
//   serial_clock_i  system clock
//   serial_reset_i  synchronous active-high reset
//   load_i          load data_i into the register
//   shift_i         shift right by one (bit_o advances to the next bit)
//   data_i          parallel payload
//   bit_o           next bit to transmit (register LSB)
module serial_tx_shifter #(
    parameter int unsigned DATA_BITS = serial_pkg::DEFAULT_DATA_BITS
) (
    input  logic                 serial_clock_i,
    input  logic                 serial_reset_i,
    input  logic                 load_i,
    input  logic                 shift_i,
    input  logic [DATA_BITS-1:0] data_i,
    output logic                 bit_o
);
    logic [DATA_BITS-1:0] sr_q;

    always_ff @(posedge serial_clock_i) begin
        if (serial_reset_i) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= data_i;
        end else if (shift_i) begin
            sr_q <= {1'b1, sr_q[DATA_BITS-1:1]};
        end
    end

    assign bit_o = sr_q[0];
endmodule

// File: rtl/serial_tx_sequencer.sv
// Sequences one SBUF transmission in all four SCON modes.
// Ports:
//   serial_clock_i  system clock, rising edge
//   serial_reset_i  synchronous active-high reset
//   bus             serial_tx_sequencer_if.slave: baud tick, SCON bits, SBUF write
//                   in; TXD/RXD pin values, P3 enables, TI set and busy out
// The shifter is loaded on the accepting SBUF write and advanced each time a
// payload bit is committed to a pin register, so its bit_o is always the next
// payload bit to send.
module serial_tx_sequencer
    import serial_pkg::*;
#(
    parameter int unsigned DATA_BITS = DEFAULT_DATA_BITS
) (
    input logic                  serial_clock_i,
    input logic                  serial_reset_i,
    serial_tx_sequencer_if.slave bus
);
    localparam int unsigned CntW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DATA_BITS - 1);

    tx_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      mode_q, mode_d;
    logic            tb8_q, tb8_d;
    logic            txd_q, txd_d;
    logic            rxd_q, rxd_d;
    logic            ti_q, ti_d;
    logic            sh_load, sh_shift, sh_bit;

    serial_tx_shifter #(
        .DATA_BITS(DATA_BITS)
    ) u_shifter (
        .serial_clock_i(serial_clock_i),
        .serial_reset_i(serial_reset_i),
        .load_i        (sh_load),
        .shift_i       (sh_shift),
        .data_i        (bus.serial_sbuf_data_i),
        .bit_o         (sh_bit)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        tb8_d    = tb8_q;
        txd_d    = txd_q;
        rxd_d    = rxd_q;
        ti_d     = 1'b0;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A coincident baud tick is deliberately ignored here
                if (bus.serial_sbuf_wr_i) begin
                    mode_d  = {bus.serial_scon7_sm0_i, bus.serial_scon6_sm1_i};
                    tb8_d   = bus.serial_scon3_tb8_i;
                    cnt_d   = '0;
                    sh_load = 1'b1;
                    state_d = StArm;
                end
            end
            StArm: begin
                if (bus.serial_br_i) begin
                    txd_d = 1'b0;
                    if (mode_q == MODE0) begin
                        rxd_d    = sh_bit;
                        sh_shift = 1'b1;
                        state_d  = StM0Lo;
                    end else begin
                        state_d = StStart;
                    end
                end
            end
            StStart: begin
                if (bus.serial_br_i) begin
                    txd_d    = sh_bit;
                    sh_shift = 1'b1;
                    state_d  = StData;
                end
            end
            StData: begin
                if (bus.serial_br_i) begin
                    if (cnt_q < CntLast) begin
                        cnt_d    = cnt_q + CntW'(1);
                        txd_d    = sh_bit;
                        sh_shift = 1'b1;
                    end else if (mode_q == MODE1) begin
                        txd_d   = 1'b1;
                        state_d = StStop;
                    end else begin
                        txd_d   = tb8_q;
                        state_d = StNinth;
                    end
                end
            end
            StNinth: begin
                if (bus.serial_br_i) begin
                    txd_d   = 1'b1;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (bus.serial_br_i) begin
                    ti_d    = 1'b1;
                    state_d = StIdle;
                end
            end
            StM0Lo: begin
                if (bus.serial_br_i) begin
                    txd_d   = 1'b1;
                    state_d = StM0Hi;
                end
            end
            StM0Hi: begin
                if (bus.serial_br_i) begin
                    if (cnt_q < CntLast) begin
                        cnt_d    = cnt_q + CntW'(1);
                        txd_d    = 1'b0;
                        rxd_d    = sh_bit;
                        sh_shift = 1'b1;
                        state_d  = StM0Lo;
                    end else begin
                        rxd_d   = 1'b1;
                        ti_d    = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge serial_clock_i) begin
        if (serial_reset_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            mode_q  <= MODE0;
            tb8_q   <= 1'b0;
            txd_q   <= 1'b1;
            rxd_q   <= 1'b1;
            ti_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            tb8_q   <= tb8_d;
            txd_q   <= txd_d;
            rxd_q   <= rxd_d;
            ti_q    <= ti_d;
        end
    end

    assign bus.serial_txd_o          = txd_q;
    assign bus.serial_rxd_o          = rxd_q;
    assign bus.serial_scon1_ti_set_o = ti_q;
    assign bus.serial_busy_o         = (state_q != StIdle);
    assign bus.serial_p3en_0_o       = (state_q == StM0Lo) || (state_q == StM0Hi);
    // P3.1 stays driven between frames once a UART mode has been used
    assign bus.serial_p3en_1_o       = (state_q != StIdle) || (mode_q != MODE0);
endmodule

// File: tb/tb_serial_tx_sequencer.sv
// Self-checking bench for serial_tx_sequencer. A frame is modelled as the list
// of {txd, rxd} pin values that must appear after each successive baud tick;
// the final entry is the tick that ends the frame and raises TI.
module tb_serial_tx_sequencer;
    logic serial_clock = 1'b0;
    logic serial_reset;

    serial_tx_sequencer_if bus ();

    serial_tx_sequencer dut (
        .serial_clock_i(serial_clock),
        .serial_reset_i(serial_reset),
        .bus           (bus)
    );

    always #5 serial_clock = ~serial_clock;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic       m_active   = 1'b0;
    logic [1:0] m_mode     = 2'b00;
    logic       m_txd      = 1'b1;
    logic       m_rxd      = 1'b1;
    logic       m_ti       = 1'b0;
    int         m_consumed = 0;
    logic [1:0] frame_q[$];

    task automatic check_eq(input string tag, input logic got, input logic exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
        end
    endtask

    task automatic build_frame(input logic [1:0] mode, input logic [7:0] d, input logic tb8);
        frame_q.delete();
        if (mode == 2'b00) begin
            for (int k = 0; k < 8; k++) begin
                frame_q.push_back({1'b0, d[k]});
                frame_q.push_back({1'b1, d[k]});
            end
            frame_q.push_back(2'b11);
        end else begin
            frame_q.push_back(2'b01);
            for (int k = 0; k < 8; k++) frame_q.push_back({d[k], 1'b1});
            if (mode != 2'b01) frame_q.push_back({tb8, 1'b1});
            frame_q.push_back(2'b11);
            frame_q.push_back(2'b11);
        end
    endtask

    task automatic model_step(input logic br, input logic wr, input logic rst,
                              input logic [7:0] d, input logic [1:0] sc, input logic tb8);
        logic [1:0] v;
        if (rst) begin
            m_active   = 1'b0;
            m_mode     = 2'b00;
            m_txd      = 1'b1;
            m_rxd      = 1'b1;
            m_ti       = 1'b0;
            m_consumed = 0;
            frame_q.delete();
        end else begin
            m_ti = 1'b0;
            if (!m_active) begin
                if (wr) begin
                    m_active   = 1'b1;
                    m_mode     = sc;
                    m_consumed = 0;
                    build_frame(sc, d, tb8);
                end
            end else if (br) begin
                v          = frame_q.pop_front();
                m_txd      = v[1];
                m_rxd      = v[0];
                m_consumed++;
                if (frame_q.size() == 0) begin
                    m_active = 1'b0;
                    m_ti     = 1'b1;
                end
            end
        end
    endtask

    // Apply one cycle of inputs, advance the model, check every output
    task automatic cycle(input logic br, input logic wr, input logic rst,
                         input logic [7:0] d, input logic [1:0] sc, input logic tb8);
        bus.serial_br_i        = br;
        bus.serial_sbuf_wr_i   = wr;
        bus.serial_sbuf_data_i = d;
        bus.serial_scon7_sm0_i = sc[1];
        bus.serial_scon6_sm1_i = sc[0];
        bus.serial_scon3_tb8_i = tb8;
        serial_reset           = rst;
        @(posedge serial_clock);
        #1;
        model_step(br, wr, rst, d, sc, tb8);
        check_eq("txd", bus.serial_txd_o, m_txd);
        check_eq("rxd", bus.serial_rxd_o, m_rxd);
        check_eq("busy", bus.serial_busy_o, m_active);
        check_eq("ti_set", bus.serial_scon1_ti_set_o, m_ti);
        check_eq("p3en_0", bus.serial_p3en_0_o, m_active && m_mode == 2'b00 && m_consumed > 0);
        check_eq("p3en_1", bus.serial_p3en_1_o, m_active || m_mode != 2'b00);
    endtask

    // One frame: write, then baud ticks every `period` clocks until done.
    // Mid-frame SBUF writes and SCON changes are injected at random.
    // abort_at > 0 resets the block after that many ticks (with a lost write).
    task automatic run_frame(input logic [1:0] mode, input logic [7:0] d, input logic tb8,
                             input int period, input int abort_at, input logic tick_on_wr);
        int   guard;
        int   ph;
        logic br;
        guard = 0;
        ph    = 0;
        cycle(tick_on_wr, 1'b1, 1'b0, d, mode, tb8);
        while (m_active && guard < 400) begin
            br = (ph == period - 1);
            ph = br ? 0 : ph + 1;
            if (abort_at > 0 && m_consumed == abort_at) begin
                cycle(1'b0, 1'b1, 1'b1, ~d, 2'($urandom), 1'($urandom));
            end else begin
                cycle(br, ($urandom_range(0, 3) == 0), 1'b0, ~d, 2'($urandom), 1'($urandom));
            end
            guard++;
        end
        check_eq("frame_end_busy", bus.serial_busy_o, 1'b0);
    endtask

    initial begin
        bus.serial_br_i        = 1'b0;
        bus.serial_sbuf_wr_i   = 1'b0;
        bus.serial_sbuf_data_i = '0;
        bus.serial_scon7_sm0_i = 1'b0;
        bus.serial_scon6_sm1_i = 1'b0;
        bus.serial_scon3_tb8_i = 1'b0;
        serial_reset           = 1'b1;

        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 8'h00, 2'b00, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 2'b01, 1'b0);

        run_frame(2'b01, 8'hA5, 1'b0, 4, 0, 1'b0);
        run_frame(2'b10, 8'h3C, 1'b1, 4, 0, 1'b0);
        run_frame(2'b00, 8'h81, 1'b0, 2, 0, 1'b0);
        run_frame(2'b01, 8'h00, 1'b0, 3, 0, 1'b0);
        // Reset during DATA bit 4 (ARM, start, bits 0..4 consumed)
        run_frame(2'b01, 8'h5A, 1'b0, 3, 7, 1'b0);
        run_frame(2'b11, 8'hC3, 1'b0, 2, 0, 1'b0);
        // Write lands in the TI cycle and with a coincident tick
        run_frame(2'b10, 8'h96, 1'b0, 3, 0, 1'b1);
        run_frame(2'b00, 8'h6B, 1'b0, 1, 0, 1'b1);

        for (int f = 0; f < 40; f++) begin
            int gap;
            int abort_at;
            gap      = $urandom_range(0, 2);
            abort_at = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 10) : 0;
            for (int g = 0; g < gap; g++) begin
                cycle(1'($urandom), 1'b0, 1'b0, 8'($urandom), 2'($urandom), 1'($urandom));
            end
            run_frame(2'($urandom), 8'($urandom), 1'($urandom), $urandom_range(1, 5),
                      abort_at, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/serial_tx_sequencer.md
# serial_tx_sequencer

Sequences one SBUF transmission for the serial port TX path in all four SCON modes. It latches the byte and TB8 on an SBUF write and drives the TXD/RXD pins, bit by bit, on baud ticks from the baud-rate generator. It drives the P3.0/P3.1 output enables and pulses the TI-set request to the SCON register. It sits between the SFR bus and the port-3 pad mux, alongside the receive controller.

## Interface
Parameters:
- DATA_BITS, 8, payload width; LSB sent first.

Ports:
- serial_clock_i  in  1  system clock; all logic on rising edge.
- serial_reset_i  in  1  synchronous, active-high reset.
- serial_br_i  in  1  baud tick, one-cycle pulse; modes 1–3: one per bit time; mode 0: one per half bit.
- serial_scon7_sm0_i  in  1  SCON.7 mode bit.
- serial_scon6_sm1_i  in  1  SCON.6 mode bit.
- serial_scon3_tb8_i  in  1  ninth bit for modes 2/3.
- serial_sbuf_wr_i  in  1  one-cycle SBUF write strobe.
- serial_sbuf_data_i  in  DATA_BITS  byte written to SBUF.
- serial_txd_o  out  1  P3.1 value: serial data in modes 1–3, shift clock in mode 0.
- serial_rxd_o  out  1  P3.0 value: serial data in mode 0.
- serial_p3en_0_o  out  1  P3.0 output enable.
- serial_p3en_1_o  out  1  P3.1 output enable.
- serial_scon1_ti_set_o  out  1  one-cycle request to set SCON.1 (TI).
- serial_busy_o  out  1  transfer in progress.

## Operation
- Mode = {sm0, sm1}:
  - 00 is mode 0 (synchronous).
  - 01 is mode 1 (10-bit frame).
  - 10 and 11 are modes 2 and 3 (11-bit frame); they are identical in this block.
- FSM states: IDLE, ARM, START, DATA, NINTH, STOP, M0_LO, M0_HI.
- IDLE:
  - On sbuf_wr, latch data, tb8 and mode; clear the bit counter; go to ARM.
  - sbuf_wr in any other state is ignored. The latched data is not altered.
- ARM, first br tick:
  - Modes 1–3: go to START, txd=0.
  - Mode 0: go to M0_LO.
- START, br tick: go to DATA; txd = bit0.
- DATA, br tick:
  - If counter < DATA_BITS-1: increment counter; txd = next bit.
  - Else, mode 1: go to STOP, txd=1.
  - Else, modes 2/3: go to NINTH, txd=tb8.
- NINTH, br tick: go to STOP, txd=1.
- STOP, br tick: go to IDLE; pulse ti_set.
- Mode 0:
  - M0_LO: txd=0, rxd = current bit. On br tick go to M0_HI, txd=1.
  - M0_HI, br tick, counter < DATA_BITS-1: go to M0_LO; increment counter; rxd = next bit.
  - M0_HI, br tick, last bit: go to IDLE; pulse ti_set; rxd=1.
- Output enables:
  - p3en_1 = 1 in every state except IDLE, and also in IDLE when the latched mode is 1–3.
  - p3en_0 = 1 only in M0_LO/M0_HI.
- busy = 1 in every state except IDLE.
- The latched mode governs the whole frame. SCON changes mid-frame take effect on the next sbuf_wr.

## Timing
- Reset values: txd=1, rxd=1, p3en_0=0, p3en_1=0, ti_set=0, busy=0; state IDLE; counter 0; latched mode 00.
- Reset asserted mid-frame aborts the transfer on the next edge with no ti_set. sbuf_wr in the same cycle as reset is lost.
- sbuf_wr at edge n sets busy=1 at n+1.
- A br tick coincident with sbuf_wr does not start the frame. The start bit or first M0_LO begins on the first tick strictly after ARM is entered.
- Every output is registered and changes on the edge that samples the br tick. Each bit is held from one tick to the next.
- ti_set is high for exactly one cycle, in the cycle after the final tick; busy falls on the same edge.
- A new sbuf_wr is accepted in that same cycle (back-to-back frames), with no idle bit time forced.
- Frame length in ticks, ARM excluded: mode 1 = 10, modes 2/3 = 11, mode 0 = 16.
- The counter is $clog2(DATA_BITS) bits wide and never wraps within a frame.

## Structure
- Shared package serial_pkg holds:
  - the FSM state encoding;
  - mode constants MODE0..MODE3;
  - DATA_BITS default.
- One sub-module, serial_tx_shifter: parallel-load DATA_BITS shift register with load/shift strobes and a bit-out. The FSM drives the strobes and owns the counter and pin registers.

## Test plan
- Mode 1, write 0xA5, br every 4 clocks → txd sequence 0,1,0,1,0,0,1,0,1,1 per tick. Then one ti_set pulse, busy low, p3en_1=1, p3en_0=0.
- Mode 2, write 0x3C with tb8=1 → 11 bits: 0, 0,0,1,1,1,1,0,0, 1, 1. ti_set after the 11th tick.
- Mode 0, write 0x81 → txd toggles 0/1 eight times, 16 ticks. rxd=1 for bits 0 and 7, 0 otherwise, stable across each txd low→high edge. p3en_0=1 throughout; rxd=1 after.
- Second sbuf_wr (0xFF) mid-frame of 0x00 → ignored; the frame completes as 0x00 with one ti_set.
- Reset asserted during DATA bit 4 → next cycle all outputs at reset values, no ti_set. A fresh write then transmits correctly.
- sbuf_wr in the ti_set cycle, and a br tick coincident with sbuf_wr → back-to-back frames with no gap. Start is delayed to the following tick.
